// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory bus bundle for mem_access_ctrl.
// master = the access controller, slave = pipeline/memory side driving requests and read data.
interface mem_access_ctrl_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = 9,
  parameter int NB_MEM_ADDR = 7
);
  logic                   enable_i;
  logic                   req_i;
  logic                   op_read_i;
  logic                   op_write_i;
  logic [1:0]             size_i;
  logic                   unsigned_i;
  logic [NB_ADDR-1:0]     addr_i;
  logic [NB_DATA-1:0]     wdata_i;
  logic                   busy_o;
  logic                   done_o;
  logic [NB_DATA-1:0]     rdata_o;
  logic                   misaligned_o;
  logic                   mem_enable_o;
  logic [NB_MEM_ADDR-1:0] mem_addr_o;
  logic [NB_DATA-1:0]     mem_data_write_o;
  logic                   mem_read_o;
  logic                   mem_write_o;
  logic [NB_DATA-1:0]     mem_data_i;

  modport master (
    input  enable_i, req_i, op_read_i, op_write_i, size_i, unsigned_i, addr_i, wdata_i,
    input  mem_data_i,
    output busy_o, done_o, rdata_o, misaligned_o,
    output mem_enable_o, mem_addr_o, mem_data_write_o, mem_read_o, mem_write_o
  );

  modport slave (
    output enable_i, req_i, op_read_i, op_write_i, size_i, unsigned_i, addr_i, wdata_i,
    output mem_data_i,
    input  busy_o, done_o, rdata_o, misaligned_o,
    input  mem_enable_o, mem_addr_o, mem_data_write_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: loads with lane extract/extend, word stores, sub-word RMW stores.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned half/word requests with misaligned_o.
module mem_access_ctrl #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = 9,
  parameter int NB_MEM_ADDR = 7
) (
  input logic               clock_i,
  input logic               reset_i,
  mem_access_ctrl_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STORE  = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;

  logic [2:0]             state;
  logic [1:0]             addr_lo_p0;
  logic [1:0]             size_p0;
  logic                   uns_p0;
  logic [15:0]            wdata_p0;
  logic                   done_q;
  logic                   misaligned_q;
  logic [NB_DATA-1:0]     rdata_q;
  logic [NB_MEM_ADDR-1:0] mem_addr_q;
  logic [NB_DATA-1:0]     mem_wdata_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic                   misalign;

  // Little-endian lane select; halfwords use addr[1] only, so addr[0] is dropped when unchecked.
  function automatic logic [NB_DATA-1:0] load_extend(
    input logic [NB_DATA-1:0] word,
    input logic [1:0]         lane,
    input logic [1:0]         size,
    input logic               uns
  );
    logic [7:0]         b;
    logic [15:0]        h;
    logic [NB_DATA-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = {{(NB_DATA-8){b[7] & ~uns}}, b};
      2'b01:   res = {{(NB_DATA-16){h[15] & ~uns}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [NB_DATA-1:0] store_merge(
    input logic [NB_DATA-1:0] word,
    input logic [15:0]        wd,
    input logic [1:0]         lane,
    input logic [1:0]         size
  );
    logic [NB_DATA-1:0] res;
    res = word;
    if (size == 2'b00) res[{lane, 3'b000} +: 8] = wd[7:0];
    else               res[{lane[1], 4'b0000} +: 16] = wd[15:0];
    return res;
  endfunction

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = ((bus.size_i == 2'b01) && bus.addr_i[0]) ||
                    (bus.size_i[1] && (bus.addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state        <= IDLE;
      addr_lo_p0   <= '0;
      size_p0      <= '0;
      uns_p0       <= 1'b0;
      wdata_p0     <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else if (!bus.enable_i) begin
      // Frozen: everything holds, but completion pulses are not repeated.
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            addr_lo_p0 <= bus.addr_i[1:0];
            size_p0    <= bus.size_i;
            uns_p0     <= bus.unsigned_i;
            wdata_p0   <= bus.wdata_i[15:0];
            if (misalign) begin
              misaligned_q <= 1'b1;
              done_q       <= 1'b1;
            end else if (bus.op_write_i) begin
              mem_addr_q <= bus.addr_i[NB_ADDR-1:2];
              if (bus.size_i[1]) begin
                mem_write_q <= 1'b1;
                mem_wdata_q <= bus.wdata_i;
                state       <= STORE;
              end else begin
                mem_read_q <= 1'b1;
                state      <= RMW_RD;
              end
            end else if (bus.op_read_i) begin
              mem_addr_q <= bus.addr_i[NB_ADDR-1:2];
              mem_read_q <= 1'b1;
              state      <= LOAD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          rdata_q    <= load_extend(bus.mem_data_i, addr_lo_p0, size_p0, uns_p0);
          mem_read_q <= 1'b0;
          done_q     <= 1'b1;
          state      <= IDLE;
        end
        STORE: begin
          mem_write_q <= 1'b0;
          done_q      <= 1'b1;
          state       <= IDLE;
        end
        RMW_RD: begin
          mem_wdata_q <= store_merge(bus.mem_data_i, wdata_p0, addr_lo_p0, size_p0);
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          state       <= RMW_WR;
        end
        RMW_WR: begin
          mem_write_q <= 1'b0;
          done_q      <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o           = (state != IDLE);
  assign bus.done_o           = done_q;
  assign bus.misaligned_o     = misaligned_q;
  assign bus.rdata_o          = rdata_q;
  assign bus.mem_enable_o     = bus.enable_i & reset_i;
  assign bus.mem_addr_o       = mem_addr_q;
  assign bus.mem_data_write_o = mem_wdata_q;
  assign bus.mem_read_o       = mem_read_q;
  assign bus.mem_write_o      = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a falling-edge word memory model.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem [0:127];

  mem_access_ctrl_if #(.NB_DATA(32), .NB_ADDR(9), .NB_MEM_ADDR(7)) bus ();

  mem_access_ctrl #(.NB_DATA(32), .NB_ADDR(9), .NB_MEM_ADDR(7)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_enable_o) begin
      if (bus.mem_write_o) mem[bus.mem_addr_o] <= bus.mem_data_write_o;
      if (bus.mem_read_o)  bus.mem_data_i <= mem[bus.mem_addr_o];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic rd, input logic [1:0] sz,
                       input logic uns, input logic [8:0] addr, input logic [31:0] wd);
    bus.op_write_i = wr;
    bus.op_read_i  = rd;
    bus.size_i     = sz;
    bus.unsigned_i = uns;
    bus.addr_i     = addr;
    bus.wdata_i    = wd;
    bus.req_i      = 1'b1;
    tick();
    bus.req_i      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable_i = 1'b1;
    bus.req_i = 1'b0; bus.op_read_i = 1'b0; bus.op_write_i = 1'b0;
    bus.size_i = 2'b10; bus.unsigned_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    tick(); tick();
    checks++; if ({bus.busy_o, bus.done_o, bus.misaligned_o} !== 3'b000) begin errors++;
      $display("FAIL reset_status: got %b expected 000", {bus.busy_o, bus.done_o, bus.misaligned_o}); end
    checks++; if ({bus.mem_read_o, bus.mem_write_o, bus.mem_enable_o} !== 3'b000) begin errors++;
      $display("FAIL reset_strobes: got %b expected 000", {bus.mem_read_o, bus.mem_write_o, bus.mem_enable_o}); end
    checks++; if (bus.rdata_o !== 32'h0 || bus.mem_addr_o !== 7'h0 || bus.mem_data_write_o !== 32'h0) begin errors++;
      $display("FAIL reset_data: got rdata %h addr %h wdata %h expected zeros", bus.rdata_o, bus.mem_addr_o, bus.mem_data_write_o); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.mem_enable_o !== 1'b1) begin errors++;
      $display("FAIL mem_enable_after_reset: got %b expected 1", bus.mem_enable_o); end
  endtask

  task automatic test_word_store_load();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    checks++; if (bus.mem_write_o !== 1'b1 || bus.mem_addr_o !== 7'd4 || bus.mem_data_write_o !== 32'hDEADBEEF) begin errors++;
      $display("FAIL sw_strobe: got wr %b addr %0d data %h expected 1 4 deadbeef", bus.mem_write_o, bus.mem_addr_o, bus.mem_data_write_o); end
    checks++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++;
      $display("FAIL sw_busy: got busy %b done %b expected 1 0", bus.busy_o, bus.done_o); end
    tick();
    checks++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin errors++;
      $display("FAIL sw_done: got done %b busy %b wr %b expected 1 0 0", bus.done_o, bus.busy_o, bus.mem_write_o); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL sw_mem: got %h expected deadbeef", mem[4]); end
    issue(1'b0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0);
    checks++; if (bus.mem_read_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++;
      $display("FAIL lw_strobe: got rd %b done %b expected 1 0", bus.mem_read_o, bus.done_o); end
    tick();
    checks++; if (bus.done_o !== 1'b1 || bus.rdata_o !== 32'hDEADBEEF) begin errors++;
      $display("FAIL lw_data: got done %b rdata %h expected 1 deadbeef", bus.done_o, bus.rdata_o); end
    tick();
    checks++; if (bus.done_o !== 1'b0 || bus.rdata_o !== 32'hDEADBEEF) begin errors++;
      $display("FAIL lw_hold: got done %b rdata %h expected 0 deadbeef", bus.done_o, bus.rdata_o); end
  endtask

  task automatic test_byte_store();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h11223344);
    tick();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 9'h013, 32'h000000AA);
    checks++; if (bus.mem_read_o !== 1'b1 || bus.mem_write_o !== 1'b0) begin errors++;
      $display("FAIL sb_rd: got rd %b wr %b expected 1 0", bus.mem_read_o, bus.mem_write_o); end
    tick();
    checks++; if (bus.mem_write_o !== 1'b1 || bus.mem_data_write_o !== 32'hAA223344 || bus.done_o !== 1'b0) begin errors++;
      $display("FAIL sb_wr: got wr %b data %h done %b expected 1 aa223344 0", bus.mem_write_o, bus.mem_data_write_o, bus.done_o); end
    tick();
    checks++; if (bus.done_o !== 1'b1 || mem[4] !== 32'hAA223344) begin errors++;
      $display("FAIL sb_done: got done %b mem %h expected 1 aa223344", bus.done_o, mem[4]); end
    issue(1'b0, 1'b1, 2'b00, 1'b0, 9'h013, 32'h0); tick();
    checks++; if (bus.rdata_o !== 32'hFFFFFFAA) begin errors++;
      $display("FAIL lb: got %h expected ffffffaa", bus.rdata_o); end
    issue(1'b0, 1'b1, 2'b00, 1'b1, 9'h013, 32'h0); tick();
    checks++; if (bus.rdata_o !== 32'h000000AA) begin errors++;
      $display("FAIL lbu: got %h expected 000000aa", bus.rdata_o); end
    issue(1'b0, 1'b1, 2'b00, 1'b1, 9'h012, 32'h0); tick();
    checks++; if (bus.rdata_o !== 32'h00000022) begin errors++;
      $display("FAIL lbu_lane2: got %h expected 00000022", bus.rdata_o); end
  endtask

  task automatic test_half_store();
    issue(1'b1, 1'b0, 2'b01, 1'b0, 9'h012, 32'h00008001); tick(); tick();
    checks++; if (bus.done_o !== 1'b1 || mem[4] !== 32'h80013344) begin errors++;
      $display("FAIL sh_mem: got done %b mem %h expected 1 80013344", bus.done_o, mem[4]); end
    issue(1'b0, 1'b1, 2'b01, 1'b0, 9'h012, 32'h0); tick();
    checks++; if (bus.rdata_o !== 32'hFFFF8001) begin errors++;
      $display("FAIL lh: got %h expected ffff8001", bus.rdata_o); end
    issue(1'b0, 1'b1, 2'b01, 1'b1, 9'h012, 32'h0); tick();
    checks++; if (bus.rdata_o !== 32'h00008001) begin errors++;
      $display("FAIL lhu: got %h expected 00008001", bus.rdata_o); end
    issue(1'b0, 1'b1, 2'b01, 1'b0, 9'h010, 32'h0); tick();
    checks++; if (bus.rdata_o !== 32'h00003344) begin errors++;
      $display("FAIL lh_low: got %h expected 00003344", bus.rdata_o); end
  endtask

  task automatic test_misaligned();
    issue(1'b0, 1'b1, 2'b10, 1'b0, 9'h011, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    checks++; if (bus.misaligned_o !== 1'b1 || bus.done_o !== 1'b1 || bus.mem_read_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++;
      $display("FAIL misaligned_reject: got mis %b done %b rd %b busy %b expected 1 1 0 0",
               bus.misaligned_o, bus.done_o, bus.mem_read_o, bus.busy_o); end
    tick();
    checks++; if (bus.misaligned_o !== 1'b0 || bus.mem_read_o !== 1'b0) begin errors++;
      $display("FAIL misaligned_pulse: got mis %b rd %b expected 0 0", bus.misaligned_o, bus.mem_read_o); end
`else
    checks++; if (bus.misaligned_o !== 1'b0 || bus.mem_read_o !== 1'b1 || bus.mem_addr_o !== 7'd4) begin errors++;
      $display("FAIL unaligned_proceed: got mis %b rd %b addr %0d expected 0 1 4",
               bus.misaligned_o, bus.mem_read_o, bus.mem_addr_o); end
    tick();
    checks++; if (bus.done_o !== 1'b1 || bus.rdata_o !== 32'h80013344) begin errors++;
      $display("FAIL unaligned_data: got done %b rdata %h expected 1 80013344", bus.done_o, bus.rdata_o); end
`endif
    tick();
  endtask

  task automatic test_noop();
    issue(1'b0, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0);
    checks++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin errors++;
      $display("FAIL noop: got done %b busy %b rd %b wr %b expected 1 0 0 0",
               bus.done_o, bus.busy_o, bus.mem_read_o, bus.mem_write_o); end
    tick();
  endtask

  task automatic test_enable_freeze();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 9'h020, 32'h01020304); tick();
    issue(1'b0, 1'b1, 2'b10, 1'b0, 9'h020, 32'h0); tick();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 9'h011, 32'h0000005A);
    @(negedge clk); #1;
    bus.enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.busy_o !== 1'b1 || bus.mem_read_o !== 1'b1 || bus.mem_write_o !== 1'b0 ||
                    bus.done_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin errors++;
        $display("FAIL freeze_%0d: got busy %b rd %b wr %b done %b en %b expected 1 1 0 0 0",
                 i, bus.busy_o, bus.mem_read_o, bus.mem_write_o, bus.done_o, bus.mem_enable_o); end
    end
    bus.enable_i = 1'b1;
    tick();
    checks++; if (bus.mem_write_o !== 1'b1 || bus.mem_data_write_o !== 32'h80015A44 || bus.done_o !== 1'b0) begin errors++;
      $display("FAIL resume_wr: got wr %b data %h done %b expected 1 80015a44 0", bus.mem_write_o, bus.mem_data_write_o, bus.done_o); end
    tick();
    checks++; if (bus.done_o !== 1'b1 || mem[4] !== 32'h80015A44) begin errors++;
      $display("FAIL resume_done: got done %b mem %h expected 1 80015a44", bus.done_o, mem[4]); end
    tick();
  endtask

  task automatic test_reset_mid_rmw();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 9'h010, 32'h00000077);
    checks++; if (bus.busy_o !== 1'b1 || bus.mem_read_o !== 1'b1) begin errors++;
      $display("FAIL rmw_started: got busy %b rd %b expected 1 1", bus.busy_o, bus.mem_read_o); end
    rst_n = 1'b0;
    tick();
    checks++; if ({bus.busy_o, bus.done_o, bus.mem_read_o, bus.mem_write_o, bus.mem_enable_o} !== 5'b00000 ||
                  bus.rdata_o !== 32'h0 || bus.mem_addr_o !== 7'h0 || bus.mem_data_write_o !== 32'h0) begin errors++;
      $display("FAIL abort_outputs: got ctl %b rdata %h addr %h wdata %h expected 00000 zeros",
               {bus.busy_o, bus.done_o, bus.mem_read_o, bus.mem_write_o, bus.mem_enable_o},
               bus.rdata_o, bus.mem_addr_o, bus.mem_data_write_o); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (mem[4] !== 32'h80015A44 || bus.busy_o !== 1'b0) begin errors++;
      $display("FAIL abort_mem: got mem %h busy %b expected 80015a44 0", mem[4], bus.busy_o); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_half_store();
    test_misaligned();
    test_noop();
    test_enable_freeze();
    test_reset_mid_rmw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
